// File: rtl/master_port.sv
// Bus master front end: latches one command, requests the arbiter, shifts the frame out and collects read data.
// Latency: start->m_request 1 edge, grant->first tx bit 1 edge, last frame/read bit->done 1 edge.
// Backpressure: waits indefinitely for grant; a new start is dropped unless idle; grant loss or read timeout aborts with err.
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rw,
    input  logic                  slave_sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  m_request,
    output logic                  m_slave_select,
    input  logic                  m_grant,
    output logic                  tx_data,
    output logic                  tx_valid,
    input  logic                  rx_data,
    input  logic                  rx_valid
);
    localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    // Index of the final frame bit for reads (rw + address) and writes (rw + address + data)
    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  RX_LAST   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, SEND, RWAIT, FIN} state_t;

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic                  sel_q, sel_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;   // {wdata, addr, rw}: bit index equals send order
    logic [CNT_W-1:0]      cnt_q, cnt_d;       // frame bit index in SEND, received bit count in RWAIT
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = REQ;
            REQ:   if (m_grant) state_d = SEND;
            SEND: begin
                if (!m_grant)                                  state_d = FIN;
                else if (cnt_q == (rw_q ? WR_LAST : RD_LAST))  state_d = rw_q ? FIN : RWAIT;
            end
            RWAIT: begin
                if (!m_grant)                             state_d = FIN;
                else if (rx_valid && cnt_q == RX_LAST)    state_d = FIN;
                else if (!rx_valid && idle_q == IDLE_LAST) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state only, so reset clears them immediately
    always_comb begin
        busy           = (state_q != IDLE);
        m_request      = (state_q == REQ) || (state_q == SEND) || (state_q == RWAIT);
        m_slave_select = m_request && sel_q;
        tx_valid       = (state_q == SEND);
        tx_data        = tx_valid && frame_q[cnt_q];
        done           = (state_q == FIN);
        err            = (state_q == FIN) && err_q;
    end

    assign rdata = rdata_q;

    // Command latch, bit counters, read shift register and abort flag
    always_comb begin
        rw_d     = rw_q;
        sel_d    = sel_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    sel_d   = slave_sel;
                    frame_d = {wdata, addr, rw};
                    err_d   = 1'b0;
                end
            end
            REQ: cnt_d = '0;
            SEND: begin
                if (!m_grant) begin
                    err_d = 1'b1;
                end else if (cnt_q == (rw_q ? WR_LAST : RD_LAST)) begin
                    cnt_d    = '0;
                    idle_d   = '0;
                    shadow_d = '0;
                    err_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RWAIT: begin
                if (!m_grant) begin
                    err_d = 1'b1;
                end else if (rx_valid) begin
                    shadow_d = {rx_data, shadow_q[DATA_WIDTH-1:1]};
                    idle_d   = '0;
                    if (cnt_q == RX_LAST) begin
                        rdata_d = {rx_data, shadow_q[DATA_WIDTH-1:1]};
                        err_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (idle_q == IDLE_LAST) begin
                    err_d = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q     <= 1'b0;
            sel_q    <= 1'b0;
            frame_q  <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rw_q     <= rw_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: directed scenarios plus random commands.
// Expected frame bits and completions are queued at issue time and consumed by a negedge monitor.
// Inputs are driven on the falling edge; DUT outputs are sampled on the falling edge.
module tb_master_port;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, rw, slave_sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          done, err, busy, m_request, m_slave_select, m_grant;
    logic          tx_data, tx_valid, rx_data, rx_valid;

    int checks = 0;
    int errors = 0;

    bit            tx_q[$];
    bit            exp_err_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] rd_model = '0;
    bit            exp_sel = 1'b0;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .slave_sel(slave_sel),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
        .m_request(m_request), .m_slave_select(m_slave_select), .m_grant(m_grant),
        .tx_data(tx_data), .tx_valid(tx_valid), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented frame bit and completion is matched against the scoreboard
    always @(negedge clk) begin
        if (tx_valid) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got bit %0b, expected no frame bit", tx_data);
            end else begin
                chk("tx_bit", 32'(tx_data), 32'(tx_q.pop_front()));
            end
        end else begin
            chk("tx_idle_zero", 32'(tx_data), 32'd0);
        end
        if (done) begin
            if (exp_err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 err=%0b, expected no completion", err);
            end else begin
                chk("done_err", 32'(err), 32'(exp_err_q.pop_front()));
                chk("done_rdata", 32'(rdata), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    // Pulse start with a command and queue its expected frame (first 'keep' bits if keep >= 0)
    task automatic issue(input bit w, input bit s, input logic [AW-1:0] a, input logic [DW-1:0] d, input int keep);
        bit fr[$];
        fr.push_back(w);
        for (int i = 0; i < AW; i++) fr.push_back(a[i]);
        if (w) for (int i = 0; i < DW; i++) fr.push_back(d[i]);
        if (keep >= 0) while (fr.size() > keep) void'(fr.pop_back());
        foreach (fr[i]) tx_q.push_back(fr[i]);
        exp_sel   = s;
        rw        = w;
        slave_sel = s;
        addr      = a;
        wdata     = d;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        rw        = 1'($urandom_range(0, 1));
        slave_sel = ~s;
        addr      = AW'($urandom);
        wdata     = DW'($urandom);
        chk("req_after_start", 32'(m_request), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int max_cyc, output int ntx);
        bit found = 1'b0;
        ntx = 0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (m_request) chk("slave_select", 32'(m_slave_select), 32'(exp_sel));
            if (tx_valid) ntx++;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(found), 32'd1);
    endtask

    // Called on the done cycle: request and tx already low, then idle the next cycle
    task automatic finish_cmd();
        chk("fin_request_low", 32'(m_request), 32'd0);
        chk("fin_tx_low", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("idle_busy_low", 32'(busy), 32'd0);
        chk("idle_done_low", 32'(done), 32'd0);
    endtask

    task automatic do_write(input bit s, input logic [AW-1:0] a, input logic [DW-1:0] d, input int g);
        int ntx;
        exp_err_q.push_back(1'b0);
        exp_rd_q.push_back(rd_model);
        if (g > 0) m_grant = 1'b0;
        issue(1'b1, s, a, d, -1);
        repeat (g) @(negedge clk);
        m_grant = 1'b1;
        wait_done(100, ntx);
        chk("write_frame_len", 32'(ntx), 32'(1 + AW + DW));
        finish_cmd();
    endtask

    // mode 0: normal read, 1: no read data (timeout), 2: grant dropped after drop_at read bits
    task automatic do_read(input bit s, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int gap, input int mode, input int drop_at, input bit noise);
        int ntx = 0;
        int k;
        if (mode == 0) rd_model = d;
        exp_err_q.push_back(mode != 0);
        exp_rd_q.push_back(rd_model);
        m_grant = 1'b1;
        issue(1'b0, s, a, DW'($urandom), -1);
        for (k = 0; k < 100; k++) begin
            rx_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            rx_data  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (tx_valid) ntx++;
            else if (ntx == 1 + AW) break;
        end
        rx_valid = 1'b0;
        chk("read_frame_len", 32'(ntx), 32'(1 + AW));
        if (mode == 1) begin
            for (k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (done) break;
            end
            chk("timeout_cycles", 32'(k), 32'(TO));
        end else begin
            for (int i = 0; i < DW; i++) begin
                if (mode == 2 && i == drop_at) begin
                    m_grant = 1'b0;
                    @(negedge clk);
                    break;
                end
                repeat (gap) @(negedge clk);
                rx_valid = 1'b1;
                rx_data  = d[i];
                @(negedge clk);
                rx_valid = 1'b0;
            end
            chk("read_done", 32'(done), 32'd1);
        end
        finish_cmd();
        m_grant = 1'b1;
    endtask

    initial begin
        int ntx;
        int cnt;
        reset = 1'b0; start = 1'b0; rw = 1'b0; slave_sel = 1'b0;
        addr = '0; wdata = '0; m_grant = 1'b0; rx_valid = 1'b0; rx_data = 1'b0;
        #1;
        chk("rst_outputs", {20'd0, rdata, done, err, busy, m_request}, 32'd0);
        chk("rst_bus", {29'd0, m_slave_select, tx_valid, tx_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: write, grant two cycles after request
        do_write(1'b1, 12'h0A5, 8'h3C, 2);
        // 2: read returning 0x69
        do_read(1'b0, 12'h001, 8'h69, 0, 0, 0, 1'b0);
        // 3: read timeout keeps rdata
        do_read(1'b1, 12'h7E1, 8'h00, 0, 1, 0, 1'b0);

        // 4: grant dropped after 5 frame bits
        exp_err_q.push_back(1'b1);
        exp_rd_q.push_back(rd_model);
        m_grant = 1'b1;
        issue(1'b1, 1'b0, 12'h5A5, 8'hC3, 5);
        ntx = 0;
        for (int k = 0; k < 50 && ntx < 5; k++) begin
            @(negedge clk);
            if (tx_valid) ntx++;
        end
        m_grant = 1'b0;
        @(negedge clk);
        chk("gl_tx_valid", 32'(tx_valid), 32'd0);
        chk("gl_done", 32'(done), 32'd1);
        chk("gl_err", 32'(err), 32'd1);
        finish_cmd();
        m_grant = 1'b1;

        // 5: second start in REQ ignored, request held without grant
        m_grant = 1'b0;
        exp_err_q.push_back(1'b0);
        exp_rd_q.push_back(rd_model);
        issue(1'b1, 1'b1, 12'h123, 8'hA5, -1);
        rw = 1'b0; addr = 12'hFFF; wdata = 8'h00; slave_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (m_request && m_slave_select && !tx_valid && !done) cnt++;
        end
        chk("req_held_50", 32'(cnt), 32'd50);
        m_grant = 1'b1;
        wait_done(100, ntx);
        chk("busy_frame_len", 32'(ntx), 32'(1 + AW + DW));
        finish_cmd();

        // 6: reset during SEND clears outputs at once, no done afterwards
        m_grant = 1'b1;
        issue(1'b1, 1'b1, 12'h0F0, 8'h5A, 3);
        ntx = 0;
        for (int k = 0; k < 50 && ntx < 3; k++) begin
            @(negedge clk);
            if (tx_valid) ntx++;
        end
        #2 reset = 1'b0;
        #1;
        chk("midrst_outputs", {20'd0, rdata, done, err, busy, m_request}, 32'd0);
        chk("midrst_bus", {29'd0, m_slave_select, tx_valid, tx_data}, 32'd0);
        rd_model = '0;
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("no_done_after_reset", 32'(cnt), 32'd0);
        do_write(1'b0, 12'hABC, 8'h81, 1);

        // Boundary: longest legal rx gaps, then grant loss while waiting for read data
        do_read(1'b1, 12'h3C3, 8'hB4, TO - 1, 0, 0, 1'b1);
        do_read(1'b0, 12'h00F, 8'h5E, 1, 2, 3, 1'b0);

        // Random commands
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), $urandom_range(0, 3));
            else
                do_read(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), $urandom_range(0, 3), 0, 0, 1'b1);
        end

        chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_err_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
